// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: gfedcba pattern table, blank code,
// decode helper and step classification for the receive-side monitor.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high gfedcba patterns, index = hex digit value.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef struct packed {
        logic       legal;
        logic [3:0] value;
    } seg_dec_t;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_UP,
        STEP_DN,
        STEP_JUMP
    } step_e;

    function automatic seg_dec_t seg_decode(input logic [6:0] pat);
        seg_dec_t r;
        r.legal = 1'b0;
        r.value = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (pat == SEG_TABLE[i]) begin
                r.legal = 1'b1;
                r.value = 4'(i);
            end
        end
        return r;
    endfunction

    function automatic step_e classify(input logic [3:0] old_v, input logic [3:0] new_v);
        logic [3:0] inc;
        logic [3:0] dec;
        inc = old_v + 4'd1;
        dec = old_v - 4'd1;
        if (new_v == inc)      return STEP_UP;
        else if (new_v == dec) return STEP_DN;
        else                   return STEP_JUMP;
    endfunction

endpackage

// File: rtl/seg_stable_filter.sv
// Two-flop synchronizer plus candidate/counter glitch filter; emits a strobe
// and the pattern each time a new stable pattern is accepted.
module seg_stable_filter
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CNT     = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena_i,
    input  logic [6:0] seg_i,
    output logic [6:0] pat_o,
    output logic       acc_o
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CNT);

    logic [6:0] sync1_q, sync2_q;
    logic [6:0] sample;
    logic [6:0] cand_q, cand_d;
    logic [7:0] cnt_q, cnt_d;
    logic [6:0] last_q;
    logic       acc_q;
    logic       hit;

    assign sample = SEG_ACTIVE_LOW ? ~sync2_q : sync2_q;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (ena_i) begin
            if (sample == cand_q) begin
                if (cnt_q < CNT_MAX) cnt_d = cnt_q + 8'd1;
            end else begin
                cand_d = sample;
                cnt_d  = 8'd1;
            end
        end
    end

    assign hit = ena_i && (cnt_d == CNT_MAX) && (cand_d != last_q);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= SEG_BLANK;
            cnt_q   <= '0;
            last_q  <= SEG_BLANK;
            acc_q   <= 1'b0;
        end else begin
            sync1_q <= seg_i;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            acc_q   <= hit;
            if (hit) last_q <= cand_d;
        end
    end

    assign pat_o = last_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/seg_rx_decode.sv
// Receive-side 7-segment monitor: filters the bus, decodes accepted patterns
// and classifies each change as step up, step down or jump.
module seg_rx_decode
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CNT     = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic [6:0] seg,
    output logic [3:0] q,
    output logic       valid,
    output logic       upd,
    output logic       err,
    output logic       step_up,
    output logic       step_dn,
    output logic       jump,
    output logic       dir
);

    logic [6:0] pat;
    logic       acc;
    seg_dec_t   dec;
    step_e      step;

    logic [3:0] q_q, q_d;
    logic       valid_q, valid_d;
    logic       dir_q, dir_d;
    logic       upd_q, upd_d;
    logic       err_q, err_d;
    logic       up_q, up_d;
    logic       dn_q, dn_d;
    logic       jump_q, jump_d;

    seg_stable_filter #(
        .STABLE_CNT    (STABLE_CNT),
        .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_filter (
        .clk  (clk),
        .rst_n(reset),
        .ena_i(ena),
        .seg_i(seg),
        .pat_o(pat),
        .acc_o(acc)
    );

    assign dec = seg_decode(pat);

    always_comb begin
        q_d     = q_q;
        valid_d = valid_q;
        dir_d   = dir_q;
        upd_d   = 1'b0;
        err_d   = 1'b0;
        up_d    = 1'b0;
        dn_d    = 1'b0;
        jump_d  = 1'b0;
        step    = STEP_NONE;
        if (acc) begin
            if (dec.legal) begin
                q_d     = dec.value;
                upd_d   = 1'b1;
                valid_d = 1'b1;
                if (valid_q) step = classify(q_q, dec.value);
            end else begin
                // Illegal codes only flag; the held q stays the comparison base.
                err_d = 1'b1;
            end
        end
        case (step)
            STEP_UP:   begin up_d = 1'b1; dir_d = 1'b1; end
            STEP_DN:   begin dn_d = 1'b1; dir_d = 1'b0; end
            STEP_JUMP: jump_d = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q     <= '0;
            valid_q <= 1'b0;
            dir_q   <= 1'b0;
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            jump_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            valid_q <= valid_d;
            dir_q   <= dir_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            jump_q  <= jump_d;
        end
    end

    assign q       = q_q;
    assign valid   = valid_q;
    assign dir     = dir_q;
    assign upd     = upd_q;
    assign err     = err_q;
    assign step_up = up_q;
    assign step_dn = dn_q;
    assign jump    = jump_q;

endmodule

// File: doc/seg_rx_decode.md
Name: seg_rx_decode

Overview:
Receive-side counterpart of the counter-to-display path. Samples a 7-segment bus driven by a counter/coder stage, possibly on another board or clock domain, and filters glitches. Decodes each stable pattern back to a 4-bit value and classifies every change as count-up, count-down or jump/load. Used to monitor and check a hex-display counter in lab builds.

Parameters:
STABLE_CNT, 4, consecutive identical samples required to accept a pattern (legal range 2..255)
SEG_ACTIVE_LOW, 1, 1 = segment lit when bit is 0; 0 = lit when bit is 1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
ena  input  1  sample enable; bus sampled only on cycles with ena=1
seg  input  7  segment bus {g,f,e,d,c,b,a}, asynchronous to clk
q  output  4  last accepted decoded value
valid  output  1  high once at least one legal pattern has been accepted
upd  output  1  1-cycle pulse when a new legal value is accepted
err  output  1  1-cycle pulse when a stable but illegal pattern is accepted
step_up  output  1  1-cycle pulse, accepted value = previous+1 mod 16
step_dn  output  1  1-cycle pulse, accepted value = previous-1 mod 16
jump  output  1  1-cycle pulse, accepted value differs from previous by any other amount
dir  output  1  last step direction: 1 = up, 0 = down; unchanged on jump

Behaviour:
- Reset (reset=0, async): all outputs 0, sync regs cleared, stability counter 0, candidate pattern register cleared.
- Input sync: seg passes through a 2-flop synchronizer on clk. Polarity is normalised to active-high after the synchronizer (invert when SEG_ACTIVE_LOW=1).
- Stability filter, evaluated only when ena=1:
  - If the normalised sample equals the candidate, increment the counter, saturating at STABLE_CNT.
  - Otherwise load the candidate with the sample and set the counter to 1.
  - Acceptance event occurs on the sample where the counter reaches STABLE_CNT and the candidate differs from the last accepted pattern.
  - ena=0 freezes counter and candidate.
- Decode table (active-high gfedcba hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. All-zero (blank) and every other code are illegal.
- On an acceptance event with a legal code:
  - q <= decoded value; upd pulses; valid <= 1.
  - If valid was already 1, compare against the old q:
    - new = q+1 mod 16 (F->0 counts as up): step_up pulses, dir <= 1.
    - new = q-1 mod 16 (0->F counts as down): step_dn pulses, dir <= 0.
    - Otherwise: jump pulses, dir unchanged.
  - If valid was 0, no step or jump pulse fires.
- On an acceptance event with an illegal code: err pulses; q, valid and dir hold.
  - The illegal pattern becomes the last accepted pattern, so it does not re-fire while held.
  - The next legal pattern is compared against the held q.
- Latency: from a seg change that is stable from then on, the pulses appear 2 (sync) + STABLE_CNT enabled samples + 1 register stage later. With ena=1 and STABLE_CNT=4 that is 7 clocks.
- All pulses are exactly one cycle wide. At most one of step_up, step_dn, jump fires per event, and it fires in the same cycle as upd.
- A reset mid-filter discards the candidate. After reset, the first legal accept sets valid without any step pulse.

Decomposition:
- Shared package seg_pkg: the 16-entry gfedcba pattern constant table, the SEG_BLANK constant, and a decode function returning {legal, value[3:0]}.
- One natural sub-module: seg_stable_filter. It contains the synchronizer plus the candidate/counter logic and outputs the accepted pattern and an accept strobe.
- The top level holds decode, compare and pulse logic.

Test Plan:
- Reset, then hold seg=~3F (active-low "0") with ena=1 → after 7 clk: upd=1, q=0, valid=1; no step/jump pulse.
- Drive 0,1,2 patterns, each held 10 clk → two step_up pulses, dir=1; then 2→1 gives step_dn, dir=0.
- F→0 and 0→F transitions → step_up and step_dn respectively (wrap-around).
- Toggle seg between "3" and "8" every 2 clk for 40 clk, STABLE_CNT=4 → no upd; then settle on "8" → one upd plus jump.
- Hold illegal 0x55 (active-high) stable → a single err pulse, q unchanged; a subsequent legal "5" → upd with correct step/jump classification against the old q.
- ena=0 while seg changes → no pulses; assert reset mid-filter → all outputs 0 immediately (async), first accept after release produces no step pulse.
